// File: rtl/jolt80_mem_arbiter.sv
// Purpose : two-requester arbiter in front of the single Jolt80 test memory port
//           (requester 0 = CPU bus, requester 1 = DMA/debug loader), round-robin on collision.
// Latency : req seen in IDLE at cycle 0, mem_data_ready at cycle N>=1 -> ready pulse at N+1;
//           one access per 3 cycles back-to-back.
// Backpressure: requesters hold req until their ready pulse; the memory holds off by
//           withholding mem_data_ready. WAIT then lasts indefinitely unless
//           JOLT80_MEM_ARB_TIMEOUT_EN is defined.
//
// Optional feature macro: JOLT80_MEM_ARB_TIMEOUT_EN
//   Defining it adds a WAIT-cycle counter. After TIMEOUT_CYCLES silent WAIT cycles the
//   access is aborted, returning rdata=0 together with the timeout_err and timeout_seen ports.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   mN_req              request level, held until mN_ready
//   mN_addr/we/acc_sz   access descriptor (acc_sz: 0 = 8-bit, 1 = 16-bit)
//   mN_wdata            write data
//   mN_rdata            registered read data for requester N
//   mN_ready            one-cycle completion pulse
//   mem_req_rdwr        memory request, high for the whole WAIT phase
//   mem_addr/we/acc_sz/wdata  descriptor latched at grant
//   mem_rdata           memory read data (already size-muxed)
//   mem_data_ready      memory completion
//   busy                arbiter is not idle
//   last_grant          index of the most recently granted requester
//   timeout_err         (optional) pulses with the ready of a timed-out access
//   timeout_seen        (optional) sticky timeout flag, cleared only by reset
module jolt80_mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic                  m0_acc_sz,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic                  m1_acc_sz,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ready,
  output logic                  mem_req_rdwr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_acc_sz,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_data_ready,
  output logic                  busy,
  output logic                  last_grant
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
  ,
  output logic                  timeout_err,
  output logic                  timeout_seen
`endif
);

  // Access-size encoding shared with the CPU package (cpu_data_acc_sz_8 / _16).
  localparam logic ACC_SZ_8 = 1'b0;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("jolt80_mem_arbiter: TIMEOUT_CYCLES must be >= 2");
  end
  if (DATA_WIDTH < 9) begin : g_bad_data_width
    $error("jolt80_mem_arbiter: DATA_WIDTH must be > 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state;

  // Arbitration: a lone requester wins outright; on a tie the one not served last wins.
  logic grant_any;
  logic grant_idx;

  always_comb begin
    grant_any = m0_req | m1_req;
    grant_idx = 1'b0;
    if (m0_req && m1_req) begin
      grant_idx = ~last_grant;
    end else if (m1_req) begin
      grant_idx = 1'b1;
    end
  end

  // Byte reads return zero in the upper bits regardless of what the memory drives there.
  logic [DATA_WIDTH-1:0] rd_capture;
  assign rd_capture = (mem_acc_sz == ACC_SZ_8) ? {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]}
                                               : mem_rdata;

  assign busy = (state != ST_IDLE);

`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      mem_req_rdwr <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_acc_sz   <= 1'b0;
      mem_wdata    <= '0;
      last_grant   <= 1'b1;  // m0 wins the first tie
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
      timeout_seen <= 1'b0;
`endif
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            last_grant   <= grant_idx;
            mem_addr     <= grant_idx ? m1_addr   : m0_addr;
            mem_we       <= grant_idx ? m1_we     : m0_we;
            mem_acc_sz   <= grant_idx ? m1_acc_sz : m0_acc_sz;
            mem_wdata    <= grant_idx ? m1_wdata  : m0_wdata;
            mem_req_rdwr <= 1'b1;
            state        <= ST_WAIT;
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
          end
        end

        // last_grant names the winner for the whole access; requester inputs are ignored here.
        ST_WAIT: begin
          if (mem_data_ready) begin
            if (!mem_we) begin
              if (last_grant) m1_rdata <= rd_capture;
              else            m0_rdata <= rd_capture;
            end
            if (last_grant) m1_ready <= 1'b1;
            else            m0_ready <= 1'b1;
            mem_req_rdwr <= 1'b0;
            state        <= ST_DONE;
          end
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
          // A completion on the same edge as the timeout wins (branch above).
          else if (wait_cnt == CNT_LAST) begin
            if (last_grant) begin
              m1_rdata <= '0;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= '0;
              m0_ready <= 1'b1;
            end
            timeout_err  <= 1'b1;
            timeout_seen <= 1'b1;
            mem_req_rdwr <= 1'b0;
            state        <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        // Ready pulse is visible during this state; requests are not sampled here.
        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jolt80_mem_arbiter.sv
// Purpose : self-checking bench for jolt80_mem_arbiter; directed scenarios plus a random phase
//           checked every cycle against a timestamp-based transaction model.
// Latency : outputs are compared on the falling edge; inputs are driven right after that compare.
// Backpressure: bench requesters hold req until the model predicts their ready pulse.
module tb_jolt80_mem_arbiter;

  localparam int  TO    = 8;
  localparam logic SZ8  = 1'b0;
  localparam logic SZ16 = 1'b1;
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
  localparam bit  TO_EN = 1'b1;
`else
  localparam bit  TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we, m0_acc_sz, m1_acc_sz;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mem_req_rdwr, mem_we, mem_acc_sz, mem_data_ready, busy, last_grant;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
  logic        timeout_err, timeout_seen;
`endif

  always #5 clk = ~clk;

  jolt80_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_acc_sz(m0_acc_sz),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_acc_sz(m1_acc_sz),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_req_rdwr(mem_req_rdwr), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_acc_sz(mem_acc_sz), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_data_ready(mem_data_ready), .busy(busy), .last_grant(last_grant)
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err), .timeout_seen(timeout_seen)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Next-cycle stimulus
  logic        nx_reset;
  logic        nx_req [2];
  logic [15:0] nx_addr[2];
  logic        nx_we  [2];
  logic        nx_sz  [2];
  logic [15:0] nx_wd  [2];
  logic        nx_mdr;
  logic [15:0] nx_mrd;
  bit          rand_mode = 1'b0;
  bit          pend[2];

  // Model: an access is described by the cycle it was granted and the cycle it completed.
  int          cyc;
  int          g_cyc, c_cyc;
  bit          timed_out, win, last, seen;
  logic [15:0] rd[2];
  logic [15:0] maddr, mwd;
  logic        mwe, msz;
  bit          e_busy, e_req, e_terr;
  bit          e_rdy[2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    g_cyc = -1; c_cyc = -1; timed_out = 0; win = 0; last = 1; seen = 0;
    rd[0] = '0; rd[1] = '0; maddr = '0; mwd = '0; mwe = 0; msz = 0;
  endtask

  task automatic clear_nx();
    nx_reset = 0; nx_mdr = 0; nx_mrd = '0;
    for (int i = 0; i < 2; i++) begin
      nx_req[i] = 0; nx_addr[i] = '0; nx_we[i] = 0; nx_sz[i] = SZ16; nx_wd[i] = '0;
    end
  endtask

  task automatic set_req(int i, logic [15:0] a, logic we, logic sz, logic [15:0] wd);
    nx_req[i] = 1; nx_addr[i] = a; nx_we[i] = we; nx_sz[i] = sz; nx_wd[i] = wd;
  endtask

  task automatic gen_random();
    for (int i = 0; i < 2; i++) begin
      if (e_rdy[i]) pend[i] = 0;
      if (!pend[i] && $urandom_range(0, 3) == 0) begin
        pend[i]    = 1;
        nx_addr[i] = 16'($urandom);
        nx_we[i]   = 1'($urandom);
        nx_sz[i]   = 1'($urandom);
        nx_wd[i]   = 16'($urandom);
      end else if (pend[i] && e_req && $urandom_range(0, 1) == 0) begin
        nx_addr[i] = 16'($urandom);  // wiggle while another access is in flight
      end
      nx_req[i] = pend[i];
    end
    nx_mdr   = ($urandom_range(0, 2) == 0);
    nx_mrd   = 16'($urandom);
    nx_reset = ($urandom_range(0, 299) == 0);
  endtask

  task automatic run_cycle();
    @(negedge clk);
    // Expected outputs in this cycle, from the access timestamps
    e_busy   = (g_cyc >= 0) && (cyc > g_cyc) && (c_cyc < 0 || cyc <= c_cyc + 1);
    e_req    = (g_cyc >= 0) && (cyc > g_cyc) && (c_cyc < 0);
    e_rdy[0] = (c_cyc >= 0) && (cyc == c_cyc + 1) && (win == 0);
    e_rdy[1] = (c_cyc >= 0) && (cyc == c_cyc + 1) && (win == 1);
    e_terr   = (c_cyc >= 0) && (cyc == c_cyc + 1) && timed_out;
    chk("m0_ready", m0_ready, e_rdy[0]);
    chk("m1_ready", m1_ready, e_rdy[1]);
    chk("m0_rdata", m0_rdata, rd[0]);
    chk("m1_rdata", m1_rdata, rd[1]);
    chk("mem_req_rdwr", mem_req_rdwr, e_req);
    chk("busy", busy, e_busy);
    chk("last_grant", last_grant, last);
    chk("mem_addr", mem_addr, maddr);
    chk("mem_we", mem_we, mwe);
    chk("mem_acc_sz", mem_acc_sz, msz);
    chk("mem_wdata", mem_wdata, mwd);
`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
    chk("timeout_err", timeout_err, e_terr);
    chk("timeout_seen", timeout_seen, seen);
`endif
    if (rand_mode) gen_random();
    reset = nx_reset;
    m0_req = nx_req[0]; m0_addr = nx_addr[0]; m0_we = nx_we[0]; m0_acc_sz = nx_sz[0]; m0_wdata = nx_wd[0];
    m1_req = nx_req[1]; m1_addr = nx_addr[1]; m1_we = nx_we[1]; m1_acc_sz = nx_sz[1]; m1_wdata = nx_wd[1];
    mem_data_ready = nx_mdr; mem_rdata = nx_mrd;
    // What the clock edge closing this cycle does
    if (nx_reset) begin
      model_reset();
    end else if (!e_busy) begin
      if (nx_req[0] || nx_req[1]) begin
        win   = (nx_req[0] && nx_req[1]) ? !last : nx_req[1];
        last  = win;
        g_cyc = cyc; c_cyc = -1; timed_out = 0;
        maddr = nx_addr[win]; mwe = nx_we[win]; msz = nx_sz[win]; mwd = nx_wd[win];
      end
    end else if (e_req) begin
      if (nx_mdr) begin
        c_cyc = cyc;
        if (!mwe) rd[win] = (msz == SZ16) ? nx_mrd : {8'h00, nx_mrd[7:0]};
      end else if (TO_EN && (cyc - g_cyc == TO)) begin
        c_cyc = cyc; timed_out = 1; rd[win] = '0; seen = 1;
      end
    end
    cyc++;
  endtask

  task automatic idle_cycles(int n);
    clear_nx();
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  initial begin
    int order, pulses;
    clear_nx();
    reset = 1;
    m0_req = 0; m1_req = 0; m0_addr = '0; m1_addr = '0; m0_we = 0; m1_we = 0;
    m0_acc_sz = 0; m1_acc_sz = 0; m0_wdata = '0; m1_wdata = '0;
    mem_data_ready = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    model_reset();
    cyc = 0;

    // 1: single 16-bit read, memory answers one cycle after grant
    set_req(0, 16'h0010, 0, SZ16, 16'h0);
    run_cycle();
    chk("rst_busy", busy, 0);
    chk("rst_last_grant", last_grant, 1);
    chk("rst_req_rdwr", mem_req_rdwr, 0);
    chk("rst_m0_rdata", m0_rdata, 16'h0);
    nx_mdr = 1; nx_mrd = 16'hBEEF;
    run_cycle();
    chk("t1_req_rdwr", mem_req_rdwr, 1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    nx_req[0] = 0; nx_mdr = 0;
    run_cycle();
    chk("t1_m0_ready", m0_ready, 1);
    chk("t1_m0_rdata", m0_rdata, 16'hBEEF);
    chk("t1_last_grant", last_grant, 0);
    chk("t1_model_rdata", rd[0], 16'hBEEF);

    // 2: both requesters from reset, held for four accesses
    clear_nx(); nx_reset = 1; run_cycle(); clear_nx();
    set_req(0, 16'h0100, 0, SZ16, 16'h0);
    set_req(1, 16'h0200, 0, SZ16, 16'h0);
    nx_mdr = 1; nx_mrd = 16'h5A5A;
    order = 0; pulses = 0;
    for (int k = 0; k < 12; k++) begin
      run_cycle();
      if (m0_ready || m1_ready) begin
        order = (order << 1) | int'(m1_ready);
        pulses++;
      end
    end
    chk("t2_pulses", pulses, 4);
    chk("t2_order", order, 4'b0101);
    idle_cycles(1);

    // 3: byte write keeps m1_rdata, byte read masks the upper byte
    set_req(1, 16'h0101, 1, SZ8, 16'h12AB);
    run_cycle();
    nx_mdr = 1; nx_mrd = 16'hFFFF;
    run_cycle();
    chk("t3_mem_addr", mem_addr, 16'h0101);
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_acc_sz", mem_acc_sz, SZ8);
    chk("t3_mem_wdata", mem_wdata, 16'h12AB);
    nx_req[1] = 0; nx_mdr = 0;
    run_cycle();
    chk("t3_m1_ready_wr", m1_ready, 1);
    chk("t3_m1_rdata_wr", m1_rdata, 16'h5A5A);
    set_req(1, 16'h0101, 0, SZ8, 16'h0);
    run_cycle();
    nx_mdr = 1; nx_mrd = 16'hFFAB;
    run_cycle();
    nx_req[1] = 0; nx_mdr = 0;
    run_cycle();
    chk("t3_m1_rdata_rd", m1_rdata, 16'h00AB);
    chk("t3_model_rdata", rd[1], 16'h00AB);

    // 4: five-cycle memory latency, address changes during WAIT
    clear_nx();
    set_req(0, 16'h1234, 0, SZ16, 16'h0);
    run_cycle();
    for (int k = 1; k <= 5; k++) begin
      nx_addr[0] = 16'hFFFF; nx_mdr = (k == 5); nx_mrd = 16'hC0DE;
      run_cycle();
      chk("t4_mem_addr_held", mem_addr, 16'h1234);
      chk("t4_no_early_ready", m0_ready, 0);
    end
    nx_req[0] = 0; nx_mdr = 0;
    run_cycle();
    chk("t4_m0_ready_c6", m0_ready, 1);
    chk("t4_m0_rdata", m0_rdata, 16'hC0DE);

    // 5: reset during WAIT aborts silently, next m1 request proceeds
    clear_nx();
    set_req(0, 16'h2000, 0, SZ16, 16'h0);
    run_cycle();
    nx_reset = 1; nx_req[0] = 0;
    run_cycle();
    chk("t5_wait_req", mem_req_rdwr, 1);
    nx_reset = 0;
    set_req(1, 16'h3000, 0, SZ16, 16'h0);
    run_cycle();
    chk("t5_abort_req", mem_req_rdwr, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_ready", m0_ready, 0);
    chk("t5_abort_last", last_grant, 1);
    nx_mdr = 1; nx_mrd = 16'h7777;
    run_cycle();
    chk("t5_m1_req", mem_req_rdwr, 1);
    chk("t5_m1_addr", mem_addr, 16'h3000);
    clear_nx();
    run_cycle();
    chk("t5_m1_ready", m1_ready, 1);
    chk("t5_m1_rdata", m1_rdata, 16'h7777);

`ifdef JOLT80_MEM_ARB_TIMEOUT_EN
    // 6: silent memory times out after TO WAIT cycles; a response on the last one wins
    clear_nx();
    set_req(0, 16'h4000, 0, SZ16, 16'h0);
    run_cycle();
    for (int k = 1; k <= TO; k++) begin
      run_cycle();
      chk("t6_no_early_ready", m0_ready, 0);
    end
    nx_req[0] = 0;
    run_cycle();
    chk("t6_to_ready", m0_ready, 1);
    chk("t6_to_err", timeout_err, 1);
    chk("t6_to_rdata", m0_rdata, 16'h0);
    chk("t6_to_seen", timeout_seen, 1);
    set_req(0, 16'h4002, 0, SZ16, 16'h0);
    run_cycle();
    for (int k = 1; k <= TO; k++) begin
      nx_mdr = (k == TO); nx_mrd = 16'h3C3C;
      run_cycle();
    end
    nx_req[0] = 0; nx_mdr = 0;
    run_cycle();
    chk("t6_late_ready", m0_ready, 1);
    chk("t6_late_no_err", timeout_err, 0);
    chk("t6_late_rdata", m0_rdata, 16'h3C3C);
    chk("t6_seen_sticky", timeout_seen, 1);
`endif

    // Random phase
    clear_nx();
    pend[0] = 0; pend[1] = 0;
    rand_mode = 1;
    for (int k = 0; k < 3000; k++) run_cycle();
    rand_mode = 0;
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/jolt80_mem_arbiter.md
Name: jolt80_mem_arbiter

Overview:
- Two-requester arbiter in front of the single Jolt80 test memory port: the CPU bus is requester 0, a DMA/debug loader is requester 1.
- Latches one request at a time, drives the memory handshake (req_rdwr / data_ready), returns read data and a one-cycle ready pulse to the winner.
- Round-robin on collision so neither requester starves.
- Sits between jolt80, the loader and quartus_ii_test_memory in the test bench and the FPGA top.

Parameters:
- ADDR_WIDTH, 16, byte address width (cpu_addr_msb_pos+1).
- DATA_WIDTH, 16, data width (cpu_data_inout_16_msb_pos+1).
- TIMEOUT_CYCLES, 64, WAIT cycles before abort (optional feature only); must be >=2.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- m0_req, m1_req  in  1  request level, held until the matching ready pulse.
- m0_addr, m1_addr  in  ADDR_WIDTH  byte address.
- m0_we, m1_we  in  1  1=write, 0=read.
- m0_acc_sz, m1_acc_sz  in  1  pkg_cpu::cpu_data_acc_sz_8 / _16.
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data.
- m0_rdata, m1_rdata  out  DATA_WIDTH  registered read data.
- m0_ready, m1_ready  out  1  one-cycle completion pulse.
- mem_req_rdwr  out  1  memory request.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_we  out  1  latched write enable.
- mem_acc_sz  out  1  latched access size.
- mem_wdata  out  DATA_WIDTH  latched write data.
- mem_rdata  in  DATA_WIDTH  memory read data, already size-muxed.
- mem_data_ready  in  1  memory completion.
- busy  out  1  state != IDLE.
- last_grant  out  1  index of the most recently granted requester.

Behaviour:
- Reset values:
  - state=IDLE; all ready outputs 0; rdata outputs 0; mem_* outputs 0; busy 0.
  - last_grant=1, so m0 wins the first tie.
- States: IDLE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant !last_grant.
  - On grant: latch addr/we/acc_sz/wdata into mem_*, set last_grant=winner, set mem_req_rdwr=1, go to WAIT.
- WAIT:
  - mem_req_rdwr held 1 and mem_* held stable.
  - Requester inputs are ignored; changes do not affect the access in flight.
  - When mem_data_ready is sampled 1: capture mem_rdata into the winner's rdata, with bits [15:8] forced 0 when acc_sz is 8-bit. Write accesses leave rdata unchanged.
  - In that same edge, clear mem_req_rdwr and go to DONE.
- DONE:
  - Winner's ready=1 for exactly this cycle; next state is IDLE unconditionally.
  - The loser's request is not sampled here.
- Requester rule: req must be low in the cycle after its ready pulse unless a new access is wanted. A req still high in that IDLE cycle is a new request.
- Latency: req high in IDLE at cycle 0 -> WAIT at cycle 1 -> with mem_data_ready at cycle N>=1, ready at N+1. Minimum 2 cycles; back-to-back throughput is one access per 3 cycles.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1.
- The non-granted requester's rdata holds its last value; its ready stays 0.
- mem_data_ready asserted in IDLE or DONE is ignored.
- Reset mid-operation, in any state:
  - Next edge returns to IDLE with mem_req_rdwr=0.
  - No ready pulse is issued; the aborted access is lost.
  - last_grant returns to 1.
- mem_addr wraps naturally; no address checking.

Optional Feature:
- Macro: JOLT80_MEM_ARB_TIMEOUT_EN.
- Defined:
  - Adds a WAIT-cycle counter, cleared on entry to WAIT.
  - If the counter reaches TIMEOUT_CYCLES without mem_data_ready: go to DONE, clear mem_req_rdwr, force winner rdata=0, pulse ready.
  - Adds output timeout_err (1 bit, reset 0). It pulses with that ready and is sticky-OR'd into status bit timeout_seen (1 bit), cleared only by reset.
  - mem_data_ready arriving on the same edge as the timeout takes priority: normal completion, no error.
- Undefined: no counter, no timeout_err/timeout_seen ports; WAIT lasts indefinitely.

Test Plan:
- Reset, then m0 read addr 0x0010 16-bit, memory data_ready 1 cycle later with 0xBEEF -> m0_ready at cycle 2, m0_rdata=0xBEEF, last_grant=0.
- m0 and m1 both assert in the same cycle after reset -> m0 served first, then m1. Hold both for 4 accesses -> grant order 0,1,0,1.
- m1 8-bit write addr 0x0101 data 0x12AB -> mem_addr=0x0101, mem_we=1, mem_acc_sz=8-bit, mem_wdata=0x12AB; m1_rdata unchanged. A following 8-bit read returning 0xFFAB yields m1_rdata=0x00AB.
- Memory latency 5 cycles, m0 changes addr during WAIT -> mem_addr stays at the latched value, m0_ready at cycle 6.
- reset pulsed during WAIT -> mem_req_rdwr=0 next cycle, no ready pulse, next m1-only request granted normally.
- JOLT80_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds -> ready and timeout_err pulse after 8 WAIT cycles, rdata=0, timeout_seen=1. Repeat with data_ready on cycle 8 -> no error.
